// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data memory access, write-back select and MEM/WB register.
// Define MEM_BYPASS_EN to forward same-cycle store data to a matching read.
module mem_wb_stage #(
   parameter int DATA_W     = 16,
   parameter int MEM_DEPTH  = 4096,
   parameter int REG_ADDR_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic                  mem_to_reg,
   input  logic [DATA_W-1:0]     read_add,
   input  logic [DATA_W-1:0]     write_data,
   input  logic [DATA_W-1:0]     alu_data,
   input  logic                  reg_write,
   input  logic [REG_ADDR_W-1:0] write_add,
   output logic [DATA_W-1:0]     data_to_write,
   output logic                  reg_write_out,
   output logic [DATA_W-1:0]     data_to_write_out,
   output logic [REG_ADDR_W-1:0] write_add_out
);
   localparam int IDX_W = $clog2(MEM_DEPTH);

   // Zero at power-up only; reset leaves the contents alone.
   logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] mem_rdata;

   assign idx = read_add[IDX_W-1:0];

   always_ff @(posedge clk)
      if (rst_n && mem_write) mem[idx] <= write_data;

`ifdef MEM_BYPASS_EN
   assign mem_rdata = !mem_read ? '0 : mem_write ? write_data : mem[idx];
`else
   assign mem_rdata = mem_read ? mem[idx] : '0;
`endif

   assign data_to_write = mem_to_reg ? mem_rdata : alu_data;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         reg_write_out     <= 1'b0;
         data_to_write_out <= '0;
         write_add_out     <= '0;
      end else begin
         reg_write_out     <= reg_write;
         data_to_write_out <= data_to_write;
         write_add_out     <= write_add;
      end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage with a reference memory model.
module tb_mem_wb_stage;
   logic        clk = 0, rst_n = 1;
   logic        mem_read = 0, mem_write = 0, mem_to_reg = 0, reg_write = 0;
   logic [15:0] read_add = 0, write_data = 0, alu_data = 0;
   logic [2:0]  write_add = 0;
   logic [15:0] data_to_write, data_to_write_out;
   logic        reg_write_out;
   logic [2:0]  write_add_out;

   typedef struct packed {logic rw; logic [15:0] d; logic [2:0] wa;} exp_t;
   exp_t        q[$];
   logic [15:0] model [int];
   int          checks = 0, errors = 0;

   mem_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .read_add(read_add), .write_data(write_data),
      .alu_data(alu_data), .reg_write(reg_write), .write_add(write_add),
      .data_to_write(data_to_write), .reg_write_out(reg_write_out),
      .data_to_write_out(data_to_write_out), .write_add_out(write_add_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   // Called with clk low; checks the combinational value, then the register after the edge.
   task automatic drive(input logic mr, mw, m2r, input logic [15:0] ra, wd, ad,
                        input logic rw, input logic [2:0] wa, input string name);
      int          i;
      logic [15:0] rd, exp_d;
      exp_t        e;
      mem_read = mr; mem_write = mw; mem_to_reg = m2r; read_add = ra;
      write_data = wd; alu_data = ad; reg_write = rw; write_add = wa;
      i = int'(ra[11:0]);
      rd = model.exists(i) ? model[i] : 16'h0000;
`ifdef MEM_BYPASS_EN
      if (mw) rd = wd;
`endif
      if (!mr) rd = 16'h0000;
      exp_d = m2r ? rd : ad;
      #2;
      checks++;
      if (data_to_write !== exp_d) begin
         errors++;
         $display("FAIL %s data_to_write got %h want %h", name, data_to_write, exp_d);
      end
      q.push_back('{rw, exp_d, wa});
      @(posedge clk);
      if (mw) model[i] = wd;
      #1;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty got 0 entries want 1", name);
      end else begin
         e = q.pop_front();
         if ({reg_write_out, data_to_write_out, write_add_out} !== e) begin
            errors++;
            $display("FAIL %s registered got %b/%h/%0d want %b/%h/%0d", name,
                     reg_write_out, data_to_write_out, write_add_out, e.rw, e.d, e.wa);
         end
      end
      @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({reg_write_out, data_to_write_out, write_add_out} !== 20'd0) begin
         errors++;
         $display("FAIL %s registered got %b/%h/%0d want 0/0000/0", name,
                  reg_write_out, data_to_write_out, write_add_out);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      drive(0, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 3'd6, "pre_reset");
      #2 rst_n = 0;
      #1 check_zero("reset_immediate");
      @(posedge clk);
      #1 check_zero("reset_held");
      @(negedge clk);
      rst_n = 1;
      drive(0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 1, 3'd5, "reset_release");
   endtask

   task automatic test_store_load();
      drive(0, 1, 0, 16'h0001, 16'h0101, 16'h0000, 0, 3'd0, "store");
      drive(1, 0, 1, 16'h0001, 16'h0000, 16'h0000, 1, 3'd1, "load");
   endtask

   task automatic test_alu_path();
      drive(1, 0, 0, 16'h0001, 16'h0000, 16'h1010, 1, 3'd2, "alu_path");
   endtask

   task automatic test_gating_alias();
      drive(0, 0, 1, 16'h0001, 16'h0000, 16'hFFFF, 1, 3'd3, "read_gated");
      drive(1, 0, 1, 16'h1001, 16'h0000, 16'hFFFF, 1, 3'd4, "alias");
      drive(1, 0, 1, 16'h0ABC, 16'h0000, 16'hFFFF, 0, 3'd7, "unwritten");
   endtask

   task automatic test_same_cycle();
      drive(0, 1, 0, 16'h0005, 16'hAAAA, 16'h0000, 0, 3'd0, "seed_5");
      drive(1, 1, 1, 16'h0005, 16'h5555, 16'h0000, 1, 3'd5, "same_cycle");
      drive(1, 0, 1, 16'h0005, 16'h0000, 16'h0000, 1, 3'd5, "after_write");
   endtask

   task automatic test_reset_mid_op();
      drive(0, 1, 0, 16'h0007, 16'h7777, 16'h0000, 1, 3'd7, "seed_7");
      mem_write = 1; read_add = 16'h0007; write_data = 16'hDEAD; reg_write = 1;
      #2 rst_n = 0;
      #1 check_zero("mid_reset_immediate");
      @(posedge clk);
      #1 check_zero("mid_reset_edge");
      @(negedge clk);
      rst_n = 1;
      drive(1, 0, 1, 16'h0007, 16'h0000, 16'h0000, 1, 3'd1, "word_kept");
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 60; n++)
         drive(1'($urandom()), 1'($urandom()), 1'($urandom()), 16'($urandom()) & 16'hF00F,
               16'($urandom()), 16'($urandom()), 1'($urandom()), 3'($urandom()), "random");
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_alu_path();
      test_gating_alias();
      test_same_cycle();
      test_reset_mid_op();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
